// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one external combinational logic unit (AND/OR/XOR/NOT) between the
// execute stage (requester 0) and the debug/test port (requester 1).
// One operation is in flight at a time:
//   IDLE : pick a requester, latch its function code and operands.
//   EXEC : the latched operation drives the logic unit; its result is
//          registered at the end of the cycle.
//   RESP : the result is offered to the owner until the owner takes it.
// Ties between the requesters are broken round-robin.
//
// Ports
//   clk_i, arst_ni                 clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o    request handshake (N = 0, 1)
//   reqN_func_i                    AND=0, OR=1, XOR=2, NOT=3
//   reqN_rs1_i, reqN_rs2_i         operands (rs2 unused by NOT)
//   reqN_rsp_valid_o / _ready_i    response handshake
//   reqN_rsp_data_o                response register (shared by both)
//   alu_func_o, alu_rs1_o/rs2_o    drive to the shared logic unit
//   alu_rd_i                       combinational result from the logic unit
//   busy_o                         high whenever the FSM is not in IDLE
//   dbg_state_o                    current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. Ready never depends on the rising edge it qualifies;
// requests are only considered in IDLE, and a response stays valid with
// stable data until its owner raises rsp_ready.
// ---------------------------------------------------------------------------
package simple_processor_pkg;
  localparam int DATA_WIDTH = 16;
endpackage

module logic_unit_arbiter #(
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,

  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [1:0]            req0_func_i,
  input  logic [DATA_WIDTH-1:0] req0_rs1_i,
  input  logic [DATA_WIDTH-1:0] req0_rs2_i,
  output logic                  req0_rsp_valid_o,
  input  logic                  req0_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] req0_rsp_data_o,

  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [1:0]            req1_func_i,
  input  logic [DATA_WIDTH-1:0] req1_rs1_i,
  input  logic [DATA_WIDTH-1:0] req1_rs2_i,
  output logic                  req1_rsp_valid_o,
  input  logic                  req1_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] req1_rsp_data_o,

  output logic [1:0]            alu_func_o,
  output logic [DATA_WIDTH-1:0] alu_rs1_o,
  output logic [DATA_WIDTH-1:0] alu_rs2_o,
  input  logic [DATA_WIDTH-1:0] alu_rd_i,

  output logic                  busy_o,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  last_grant_q;
  logic                  owner_q;
  logic [1:0]            func_q;
  logic [DATA_WIDTH-1:0] rs1_q;
  logic [DATA_WIDTH-1:0] rs2_q;
  logic [DATA_WIDTH-1:0] rsp_q;

  logic                  gnt_valid;
  logic                  gnt_id;
  logic                  accept;
  logic                  owner_rsp_ready;

  // Grant selection: a lone requester wins; on a tie the requester that was
  // not served last wins, which makes continuous contention alternate.
  always_comb begin
    gnt_valid = req0_valid_i | req1_valid_i;
    if (req0_valid_i && req1_valid_i) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req1_valid_i;
    end
  end

  assign accept          = (state_q == IDLE) && gnt_valid;
  assign owner_rsp_ready = owner_q ? req1_rsp_ready_i : req0_rsp_ready_i;

  // Ready is masked by reset so that nothing appears accepted while the
  // block is held in reset, even if requesters keep valid high.
  assign req0_ready_o = arst_ni && accept && !gnt_id;
  assign req1_ready_o = arst_ni && accept &&  gnt_id;

  // FSM: state register
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation latch, round-robin pointer and response register.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      func_q       <= 2'd0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rsp_q        <= '0;
    end else begin
      if (accept) begin
        owner_q      <= gnt_id;
        last_grant_q <= gnt_id;
        func_q       <= gnt_id ? req1_func_i : req0_func_i;
        rs1_q        <= gnt_id ? req1_rs1_i  : req0_rs1_i;
        rs2_q        <= gnt_id ? req1_rs2_i  : req0_rs2_i;
      end
      if (state_q == EXEC) begin
        rsp_q <= alu_rd_i;
      end
    end
  end

  assign alu_func_o = func_q;
  assign alu_rs1_o  = rs1_q;
  assign alu_rs2_o  = rs2_q;

  assign req0_rsp_valid_o = (state_q == RESP) && !owner_q;
  assign req1_rsp_valid_o = (state_q == RESP) &&  owner_q;
  assign req0_rsp_data_o  = rsp_q;
  assign req1_rsp_data_o  = rsp_q;

  assign busy_o      = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Bench for logic_unit_arbiter. The shared logic unit is modelled here as a
// combinational block driven by the arbiter's alu_* outputs. A negedge
// monitor pushes the expected result (with requester id) whenever a request
// handshake is about to happen and pops/compares it when a response is
// consumed. Scenario tasks drive stimulus and check control behaviour inline.
// ---------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  localparam int W = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic arst_ni;
  always #5 clk = ~clk;

  logic         req0_valid, req0_ready, req0_rsp_valid, req0_rsp_ready;
  logic [1:0]   req0_func;
  logic [W-1:0] req0_rs1, req0_rs2, req0_rsp_data;
  logic         req1_valid, req1_ready, req1_rsp_valid, req1_rsp_ready;
  logic [1:0]   req1_func;
  logic [W-1:0] req1_rs1, req1_rs2, req1_rsp_data;
  logic [1:0]   alu_func;
  logic [W-1:0] alu_rs1, alu_rs2, alu_rd;
  logic         busy;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;

  logic_unit_arbiter #(.DATA_WIDTH(W)) dut (
    .clk_i            (clk),
    .arst_ni          (arst_ni),
    .req0_valid_i     (req0_valid),
    .req0_ready_o     (req0_ready),
    .req0_func_i      (req0_func),
    .req0_rs1_i       (req0_rs1),
    .req0_rs2_i       (req0_rs2),
    .req0_rsp_valid_o (req0_rsp_valid),
    .req0_rsp_ready_i (req0_rsp_ready),
    .req0_rsp_data_o  (req0_rsp_data),
    .req1_valid_i     (req1_valid),
    .req1_ready_o     (req1_ready),
    .req1_func_i      (req1_func),
    .req1_rs1_i       (req1_rs1),
    .req1_rs2_i       (req1_rs2),
    .req1_rsp_valid_o (req1_rsp_valid),
    .req1_rsp_ready_i (req1_rsp_ready),
    .req1_rsp_data_o  (req1_rsp_data),
    .alu_func_o       (alu_func),
    .alu_rs1_o        (alu_rs1),
    .alu_rs2_o        (alu_rs2),
    .alu_rd_i         (alu_rd),
    .busy_o           (busy),
    .dbg_state_o      (dbg_state)
  );

  function automatic logic [W-1:0] ref_logic(input logic [1:0] f,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    case (f)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  // shared logic unit
  always_comb alu_rd = ref_logic(alu_func, alu_rs1, alu_rs2);

  // scoreboard monitor
  always @(negedge clk) begin
    if (arst_ni) begin
      if (req0_ready && req1_ready) begin
        total++; bad++;
        $display("FAIL dual_ready: both readys high at %0t", $time);
      end
      if (req0_rsp_valid && req1_rsp_valid) begin
        total++; bad++;
        $display("FAIL dual_rsp_valid: both rsp_valid high at %0t", $time);
      end
      if (req0_valid && req0_ready)
        exp_q.push_back({1'b0, ref_logic(req0_func, req0_rs1, req0_rs2)});
      if (req1_valid && req1_ready)
        exp_q.push_back({1'b1, ref_logic(req1_func, req1_rs1, req1_rs2)});
      if (req0_rsp_valid && req0_rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp0_unexpected: got %h, queue empty", req0_rsp_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({1'b0, req0_rsp_data} !== mon_exp) begin
            bad++;
            $display("FAIL rsp0_data: got id0 %h, expected id%0d %h",
                     req0_rsp_data, mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
      if (req1_rsp_valid && req1_rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp1_unexpected: got %h, queue empty", req1_rsp_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({1'b1, req1_rsp_data} !== mon_exp) begin
            bad++;
            $display("FAIL rsp1_data: got id1 %h, expected id%0d %h",
                     req1_rsp_data, mon_exp[W], mon_exp[W-1:0]);
          end
        end
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clk); #1 arst_ni = 1'b0;
    @(posedge clk); #1 arst_ni = 1'b1;
  endtask

  task automatic test_reset();
    arst_ni = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_func = 2'd0; req0_rs1 = '0; req0_rs2 = '0;
    req1_func = 2'd0; req1_rs1 = '0; req1_rs2 = '0;
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({req0_ready, req1_ready, busy, req0_rsp_valid, req1_rsp_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {req0_ready, req1_ready, busy, req0_rsp_valid, req1_rsp_valid});
    end
    total++;
    if ({alu_func, alu_rs1, alu_rs2, dbg_state} !== '0) begin
      bad++;
      $display("FAIL reset_alu: got func=%0d rs1=%h rs2=%h st=%0d expected all 0",
               alu_func, alu_rs1, alu_rs2, dbg_state);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    arst_ni = 1'b1;
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_func = 2'd0; req0_rs1 = 16'hF0F0; req0_rs2 = 16'hFF00;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    #1;
    total++;
    if ({busy, dbg_state, req0_rsp_valid} !== {1'b1, S_EXEC, 1'b0}) begin
      bad++; $display("FAIL single_exec: got busy=%b st=%0d rspv=%b expected 1 1 0",
                      busy, dbg_state, req0_rsp_valid);
    end
    total++;
    if ({alu_func, alu_rs1, alu_rs2} !== {2'd0, 16'hF0F0, 16'hFF00}) begin
      bad++; $display("FAIL single_alu: got %0d %h %h expected 0 f0f0 ff00",
                      alu_func, alu_rs1, alu_rs2);
    end
    @(posedge clk); #1;
    total++;
    if ({busy, req0_rsp_valid, req0_rsp_data} !== {1'b1, 1'b1, 16'hF000}) begin
      bad++; $display("FAIL single_resp: got busy=%b v=%b d=%h expected 1 1 f000",
                      busy, req0_rsp_valid, req0_rsp_data);
    end
    req0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_rsp_ready = 1'b0;
    total++;
    if ({busy, req0_rsp_valid} !== 2'b00) begin
      bad++; $display("FAIL single_idle: got %b expected 00", {busy, req0_rsp_valid});
    end
  endtask

  task automatic test_tie();
    pulse_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_func = 2'd1; req0_rs1 = 16'h00F0; req0_rs2 = 16'h0F00;
    req1_valid = 1'b1; req1_func = 2'd2; req1_rs1 = 16'hFFFF; req1_rs2 = 16'h00FF;
    req0_rsp_ready = 1'b1; req1_rsp_ready = 1'b1;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL tie_first: got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({req0_rsp_valid, req0_rsp_data, req1_ready} !== {1'b1, 16'h0FF0, 1'b0}) begin
      bad++; $display("FAIL tie_rsp0: got v=%b d=%h r1=%b expected 1 0ff0 0",
                      req0_rsp_valid, req0_rsp_data, req1_ready);
    end
    @(posedge clk); #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL tie_second: got %b expected 01", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({req1_rsp_valid, req1_rsp_data} !== {1'b1, 16'hFF00}) begin
      bad++; $display("FAIL tie_rsp1: got v=%b d=%h expected 1 ff00",
                      req1_rsp_valid, req1_rsp_data);
    end
    @(posedge clk); #1;
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_func = 2'd3; req1_rs1 = 16'h1234;
    req1_rs2 = W'($urandom_range(0, 16'hFFFF));
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_accept: got %b expected 01", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_func = 2'd0; req0_rs1 = 16'hA5A5; req0_rs2 = 16'h0F0F;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({req1_rsp_valid, req1_rsp_data, req0_ready} !== {1'b1, 16'hEDCB, 1'b0}) begin
        bad++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h r0=%b expected 1 edcb 0",
                        i, req1_rsp_valid, req1_rsp_data, req0_ready);
      end
      if (i < 4) begin
        @(posedge clk); #1;
      end
    end
    req1_rsp_ready = 1'b1; req0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    req1_rsp_ready = 1'b0;
    total++;
    if ({busy, req0_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_release: got busy,r0=%b expected 01", {busy, req0_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    req0_rsp_ready = 1'b0;
  endtask

  task automatic test_contention();
    int   done;
    int   cyc;
    logic exp_g;
    logic hs0, hs1;
    done = 0; cyc = 0; exp_g = 1'b0;
    pulse_reset();
    @(posedge clk); #1;
    req0_rsp_ready = 1'b1; req1_rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_func = 2'($urandom_range(0, 3)); req0_rs1 = W'($urandom_range(0, 16'hFFFF));
    req0_rs2  = W'($urandom_range(0, 16'hFFFF));
    req1_func = 2'($urandom_range(0, 3)); req1_rs1 = W'($urandom_range(0, 16'hFFFF));
    req1_rs2  = W'($urandom_range(0, 16'hFFFF));
    while (done < 8 && cyc < 200) begin
      #1;
      hs0 = req0_ready; hs1 = req1_ready;
      if (hs0 || hs1) begin
        total++;
        if (hs1 !== exp_g) begin
          bad++; $display("FAIL grant_order: op %0d got req%0d expected req%0d",
                          done, hs1, exp_g);
        end
        exp_g = ~exp_g;
        done++;
      end
      @(posedge clk); #1;
      cyc++;
      if (hs0) begin
        req0_func = 2'($urandom_range(0, 3)); req0_rs1 = W'($urandom_range(0, 16'hFFFF));
        req0_rs2  = W'($urandom_range(0, 16'hFFFF));
      end
      if (hs1) begin
        req1_func = 2'($urandom_range(0, 3)); req1_rs1 = W'($urandom_range(0, 16'hFFFF));
        req1_rs2  = W'($urandom_range(0, 16'hFFFF));
      end
    end
    total++;
    if (done != 8) begin
      bad++; $display("FAIL contention_timeout: got %0d ops expected 8", done);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if ({busy, exp_q.size() == 0} !== 2'b01) begin
      bad++; $display("FAIL contention_drain: got busy=%b pending=%0d expected 0 0",
                      busy, exp_q.size());
    end
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    req0_rsp_ready = 1'b1; req1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_func = 2'd2; req0_rs1 = 16'h5555; req0_rs2 = 16'h3333;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    total++;
    if (dbg_state !== S_EXEC) begin
      bad++; $display("FAIL rmid_exec: got state %0d expected 1", dbg_state);
    end
    arst_ni = 1'b0;
    #1;
    total++;
    if ({req0_ready, req1_ready, busy, req0_rsp_valid, req1_rsp_valid,
         alu_func, alu_rs1, alu_rs2} !== '0) begin
      bad++; $display("FAIL rmid_zero: got r=%b%b busy=%b v=%b%b alu=%0d %h %h expected all 0",
                      req0_ready, req1_ready, busy, req0_rsp_valid, req1_rsp_valid,
                      alu_func, alu_rs1, alu_rs2);
    end
    exp_q.delete();
    @(posedge clk); #1;
    arst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({busy, req0_rsp_valid, req1_rsp_valid} !== 3'b000) begin
        bad++; $display("FAIL rmid_norsp: cycle %0d got %b expected 000",
                        i, {busy, req0_rsp_valid, req1_rsp_valid});
      end
    end
    req0_valid = 1'b1; req0_func = 2'd0; req0_rs1 = 16'hFFFF; req0_rs2 = 16'h8001;
    req1_valid = 1'b1; req1_func = 2'd3; req1_rs1 = 16'h00FF; req1_rs2 = 16'h0000;
    #1;
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rmid_tie: got %b expected 10", {req0_ready, req1_ready});
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 10 && !req1_ready; i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL rmid_timeout: got r1=%b expected 1", req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    for (int i = 0; i < 10 && busy; i++) begin
      @(posedge clk); #1;
    end
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b0;
  endtask

  task automatic test_nonowner();
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_func = 2'd1; req0_rs1 = 16'h1200; req0_rs2 = 16'h0034;
    #1;
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL nonowner_accept: got %b expected 1", req0_ready);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({dbg_state, req0_rsp_valid, req1_rsp_valid, req0_rsp_data} !==
          {S_RESP, 1'b1, 1'b0, 16'h1234}) begin
        bad++; $display("FAIL nonowner_hold: cycle %0d got st=%0d v=%b%b d=%h expected 2 10 1234",
                        i, dbg_state, req0_rsp_valid, req1_rsp_valid, req0_rsp_data);
      end
      @(posedge clk); #1;
    end
    req0_rsp_ready = 1'b1;
    @(posedge clk); #1;
    req0_rsp_ready = 1'b0; req1_rsp_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL nonowner_idle: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_contention();
    test_reset_mid();
    test_nonowner();
    @(posedge clk); #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

- Shares one combinational logic unit (AND/OR/XOR/NOT on `DATA_WIDTH` operands) between two requesters.
- Requester 0 is the execute stage; requester 1 is the debug/test port.
- Operation: accept one request, latch its operands, drive the logic unit for one cycle, register the result, and hold the response until its owner takes it.
- Arbitration is round-robin, with one operation in flight at a time.

## Interface
- `DATA_WIDTH`, default `simple_processor_pkg::DATA_WIDTH`: operand and result width.
- `clk_i  in  1`: single clock; all state updates on its rising edge.
- `arst_ni  in  1`: reset, asynchronous and active-low.
- `reqN_valid_i  in  1` (N=0,1): requester N presents an operation.
- `reqN_ready_o  out  1`: request accepted on a cycle where valid and ready are both high.
- `reqN_func_i  in  2`: function code AND=0, OR=1, XOR=2, NOT=3.
- `reqN_rs1_i  in  DATA_WIDTH`: operand 1.
- `reqN_rs2_i  in  DATA_WIDTH`: operand 2 (ignored for NOT).
- `reqN_rsp_valid_o  out  1`: result available for requester N.
- `reqN_rsp_ready_i  in  1`: requester N consumes the result.
- `reqN_rsp_data_o  out  DATA_WIDTH`: result, valid while `reqN_rsp_valid_o`.
- `alu_func_o  out  2`: function code to the shared logic unit.
- `alu_rs1_o  out  DATA_WIDTH`: operand 1 to the logic unit.
- `alu_rs2_o  out  DATA_WIDTH`: operand 2 to the logic unit.
- `alu_rd_i  in  DATA_WIDTH`: combinational result from the logic unit.
- `busy_o  out  1`: high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE, grant selection**
  - Neither valid: no grant.
  - One valid: that requester is granted.
  - Both valid: the requester other than `last_grant` is granted.
- **IDLE, handshake**
  - `reqN_ready_o` = (state==IDLE) && (grant==N); combinational from both valids.
  - On a handshake, latch func, rs1, rs2 and owner; set `last_grant` = owner; go to EXEC.
- **EXEC**
  - `alu_*_o` driven from the latched registers.
  - At the clock edge, `alu_rd_i` is captured into the response register; go to RESP.
- **RESP**
  - `reqOwner_rsp_valid_o`=1; the other requester's `rsp_valid`=0.
  - On `rsp_ready` from the owner, go to IDLE.
  - A `rsp_ready` from the non-owner is ignored.
- **Response data**
  - Both `reqN_rsp_data_o` carry the response register.
  - Consumers sample it only with their own `rsp_valid`.
- **ALU drive**
  - `alu_*_o` always reflect the latched registers.
  - After reset they are all-zero (func=AND, operands 0).
  - The logic unit is combinational; no width change. Result width equals `DATA_WIDTH`.
- Request inputs are ignored outside IDLE. `reqN_ready_o`=0 in EXEC and RESP.

## Timing
- **Reset values:** state=IDLE, `last_grant`=1 (requester 0 wins the first tie), owner=0, latched func/operands=0, response register=0.
- **Outputs during reset:** all `ready_o`, `rsp_valid_o` and `busy_o` = 0; `alu_*_o` = 0.
- **Latency:** handshake at edge N → EXEC during cycle N+1 → `rsp_valid` high from cycle N+2.
- **Throughput:** minimum 3 cycles per operation (handshake, EXEC, response taken in first RESP cycle). The next request can be accepted in the cycle after the response handshake.
- **Response hold:** `rsp_valid` and data are held stable in RESP indefinitely until `rsp_ready`.
- **Simultaneous events:** a requester whose response is being consumed may already hold `valid` high. It is considered for grant in the following IDLE cycle; IDLE is never skipped.
- **Reset mid-operation:** asynchronous return to IDLE. An in-flight operation is dropped with no response. `last_grant` returns to 1.
- **Fairness:** with both requesters continuously valid, grants strictly alternate 0,1,0,1…

## Test plan
- **Reset, then single request:** req0 AND, rs1=0xF0F0, rs2=0xFF00 → `req0_ready_o` high in IDLE; `req0_rsp_valid_o` two cycles after handshake with data 0xF000; `busy_o` high for EXEC+RESP.
- **Tie after reset:** both valid, req0 OR(0x00F0,0x0F00), req1 XOR(0xFFFF,0x00FF) → req0 granted first with result 0x0FF0; req1 granted next IDLE with result 0xFF00.
- **Response backpressure:** req1 NOT rs1=0x1234 with `rsp_ready` low for 5 cycles → `req1_rsp_valid_o` and data ~0x1234 held stable for all 5 cycles; `req0_ready_o` stays 0 even with req0 valid; return to IDLE one cycle after `rsp_ready`.
- **Continuous contention for 8 operations** → grant order 0,1,0,1,…; each result matches the reference logic model; no response goes to the wrong requester.
- **Reset asserted in EXEC** → all outputs zero immediately; no `rsp_valid` after release; the next tie is granted to req0.
- **Non-owner `rsp_ready` in RESP:** req1 asserts `rsp_ready` while req0 owns the response → FSM stays in RESP and `req0_rsp_valid_o` remains high.
